// File: rtl/nivel_comida_ctrl_if.sv
// Food-level controller bundle: pet-FSM side inputs (button, test mode,
// eating flag) and level/button/debug outputs.
interface nivel_comida_ctrl_if;
  logic       boton_comida_raw;
  logic       test_mode;
  logic       comiendo;
  logic [1:0] nivel;
  logic       boton_comida;
  logic       boton_pulse;
  logic [1:0] estado;
  logic       tick_ms;

  modport master (
    output boton_comida_raw, test_mode, comiendo,
    input  nivel, boton_comida, boton_pulse, estado, tick_ms
  );

  modport slave (
    input  boton_comida_raw, test_mode, comiendo,
    output nivel, boton_comida, boton_pulse, estado, tick_ms
  );
endinterface

// File: rtl/nivel_comida_ctrl.sv
// Food level generator and food-button debouncer feeding the pet-state FSM.
// A millisecond tick drives level decay (NORMAL), refill (FEEDING) and the
// debounce timer; HOLD freezes the level while test mode is active.
module nivel_comida_ctrl #(
  parameter int unsigned PRESCALE    = 50000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned DECAY_MS    = 10000,
  parameter int unsigned FEED_MS     = 1000
) (
  input logic               clk,
  input logic               reset,
  nivel_comida_ctrl_if.slave bus
);

  localparam int unsigned PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DBW = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned DCW = $clog2(DECAY_MS + 1);
  localparam int unsigned FDW = $clog2(FEED_MS + 1);

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    FEEDING = 2'b01,
    HOLD    = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_pre;
  logic             w_tick;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_btn;
  logic             r_pulse;
  logic [DBW-1:0]   r_db_cnt;
  logic [DBW-1:0]   w_db_next;
  logic [1:0]       r_nivel;
  logic [DCW-1:0]   r_decay;
  logic [DCW-1:0]   w_decay_next;
  logic [FDW-1:0]   r_feed;
  logic [FDW-1:0]   w_feed_next;
  logic [1:0]       w_estado;

  assign w_tick       = (r_pre == PW'(PRESCALE - 1));
  assign w_db_next    = r_db_cnt + 1'b1;
  assign w_decay_next = r_decay + 1'b1;
  assign w_feed_next  = r_feed + 1'b1;

  // Millisecond prescaler: free-running 0..PRESCALE-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else             r_pre <= r_pre + 1'b1;
  end

  // Button synchronizer and debouncer; press pulse coincides with the 0->1 accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_btn    <= 1'b0;
      r_pulse  <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= ~bus.boton_comida_raw;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      if (r_sync2 == r_btn) begin
        r_db_cnt <= '0;
      end else if (w_tick) begin
        if (w_db_next == DBW'(DEBOUNCE_MS)) begin
          r_btn    <= r_sync2;
          r_pulse  <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= w_db_next;
        end
      end
    end
  end

  // Level FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= NORMAL;
    else        r_state <= w_next;
  end

  // Level FSM next state: test_mode overrides comiendo
  always_comb begin
    w_next = r_state;
    if (bus.test_mode) begin
      w_next = HOLD;
    end else begin
      case (r_state)
        NORMAL:  w_next = bus.comiendo ? FEEDING : NORMAL;
        FEEDING: w_next = bus.comiendo ? FEEDING : NORMAL;
        default: w_next = NORMAL;
      endcase
    end
  end

  // Level FSM outputs
  always_comb begin
    w_estado = r_state;
  end

  // Level datapath; a transition cycle suppresses any terminal tick and zeroes both timers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nivel <= 2'd3;
      r_decay <= '0;
      r_feed  <= '0;
    end else if (w_next != r_state) begin
      r_decay <= '0;
      r_feed  <= '0;
    end else begin
      case (r_state)
        NORMAL: begin
          r_feed <= '0;
          if (w_tick) begin
            if (w_decay_next == DCW'(DECAY_MS)) begin
              r_decay <= '0;
              if (r_nivel != 2'd0) r_nivel <= r_nivel - 2'd1;
            end else begin
              r_decay <= w_decay_next;
            end
          end
        end
        FEEDING: begin
          r_decay <= '0;
          if (w_tick) begin
            if (w_feed_next == FDW'(FEED_MS)) begin
              r_feed <= '0;
              if (r_nivel != 2'd3) r_nivel <= r_nivel + 2'd1;
            end else begin
              r_feed <= w_feed_next;
            end
          end
        end
        default: begin
          r_decay <= '0;
          r_feed  <= '0;
        end
      endcase
    end
  end

  assign bus.nivel        = r_nivel;
  assign bus.boton_comida = r_btn;
  assign bus.boton_pulse  = r_pulse;
  assign bus.estado       = w_estado;
  assign bus.tick_ms      = w_tick;

endmodule
